// File: rtl/kernel_dup_scanner.sv
// kernel_dup_scanner
//
// Purpose: holds a loaded kernel (lowered weight vector) and scans it for
// repeated values. For each element j whose value already appeared earlier,
// it emits the index pair (smallest matching i, j) over a valid/ready
// handshake. It also keeps a saturating count of the pairs emitted by the
// current scan.
//
// Optional build macro:
//   DUPSCAN_SKIP_ZERO_EN  - zero weights never match, so they produce no
//                           pairs. Zeros are left to the sparsity path.
//                           When undefined, zeros match like any other value.
//
// Parameters:
//   WORD_WIDTH  weight and index width. MAX_KE must not exceed 2**WORD_WIDTH.
//   MAX_KE      weight buffer depth, i.e. the maximum kernel elements.
//
// Ports:
//   clk         clock, rising edge
//   reset_n     asynchronous active-low reset; clears the buffer too
//   ld_en       write ld_data at the load pointer (IDLE only)
//   ld_data     weight value
//   ke_size     element count, sampled with start
//   start       begin scan (IDLE only)
//   busy        high in CMP, EMIT and DONE
//   done        one-cycle pulse at scan end
//   pair_valid  idx1/idx2 hold a pair
//   pair_ready  consumer accepts the pair
//   idx1        first-occurrence index
//   idx2        duplicate index (always > idx1)
//   pair_cnt    pairs emitted this scan, saturating
//
// States:
//   IDLE | accept loads and start
//   CMP  | one compare per cycle, wbuf[i] vs wbuf[j]
//   EMIT | hold pair until pair_valid && pair_ready
//   DONE | done pulse, load pointer cleared

module kernel_dup_scanner #(
  parameter int WORD_WIDTH = 8,
  parameter int MAX_KE     = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ld_en,
  input  logic [WORD_WIDTH-1:0] ld_data,
  input  logic [WORD_WIDTH-1:0] ke_size,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pair_valid,
  input  logic                  pair_ready,
  output logic [WORD_WIDTH-1:0] idx1,
  output logic [WORD_WIDTH-1:0] idx2,
  output logic [WORD_WIDTH-1:0] pair_cnt
);

  localparam int AW = (MAX_KE > 1) ? $clog2(MAX_KE) : 1;
  localparam int PW = $clog2(MAX_KE + 1);
  localparam logic [PW-1:0]         PTR_FULL = PW'(MAX_KE);
  localparam logic [WORD_WIDTH:0]   MAX_KE_X = (WORD_WIDTH + 1)'(MAX_KE);
  localparam logic [WORD_WIDTH-1:0] TWO      = WORD_WIDTH'(2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMP,
    S_EMIT,
    S_DONE
  } state_t;

  state_t state;

  logic [WORD_WIDTH-1:0] wbuf [MAX_KE];
  logic [PW-1:0]         wr_ptr;
  logic                  ld_accept;

  logic [WORD_WIDTH-1:0] n_q;
  logic [WORD_WIDTH-1:0] i_q;
  logic [WORD_WIDTH-1:0] j_q;

  logic [WORD_WIDTH-1:0] a_val;
  logic [WORD_WIDTH-1:0] b_val;
  logic                  hit;
  logic                  i_last;
  logic                  j_last;
  logic [WORD_WIDTH:0]   ke_ext;
  logic [WORD_WIDTH-1:0] n_sel;

  // Writes past the end of the buffer are dropped rather than wrapped.
  assign ld_accept = (state == S_IDLE) && ld_en && (wr_ptr != PTR_FULL);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < MAX_KE; k++) begin
        wbuf[k] <= '0;
      end
      wr_ptr <= '0;
    end else begin
      if (state == S_DONE) begin
        wr_ptr <= '0;
      end else if (ld_accept) begin
        wbuf[wr_ptr[AW-1:0]] <= ld_data;
        wr_ptr               <= wr_ptr + 1'b1;
      end
    end
  end

  // i and j stay below n <= MAX_KE, so the low AW bits address the buffer.
  assign a_val = wbuf[i_q[AW-1:0]];
  assign b_val = wbuf[j_q[AW-1:0]];

  always_comb begin
    hit = 1'b0;
`ifdef DUPSCAN_SKIP_ZERO_EN
    hit = (a_val == b_val) && (b_val != '0);
`else
    hit = (a_val == b_val);
`endif
  end

  // Widened by one bit so i+1 / j+1 cannot wrap at the top of the index range.
  assign i_last = (({1'b0, i_q} + 1'b1) >= {1'b0, j_q});
  assign j_last = (({1'b0, j_q} + 1'b1) >= {1'b0, n_q});

  assign ke_ext = {1'b0, ke_size};
  assign n_sel  = (ke_ext > MAX_KE_X) ? MAX_KE_X[WORD_WIDTH-1:0] : ke_size;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      n_q        <= '0;
      i_q        <= '0;
      j_q        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pair_valid <= 1'b0;
      idx1       <= '0;
      idx2       <= '0;
      pair_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            pair_cnt <= '0;
            n_q      <= n_sel;
            i_q      <= '0;
            j_q      <= WORD_WIDTH'(1);
            busy     <= 1'b1;
            if (n_sel >= TWO) begin
              state <= S_CMP;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end

        S_CMP: begin
          if (hit) begin
            idx1       <= i_q;
            idx2       <= j_q;
            pair_valid <= 1'b1;
            state      <= S_EMIT;
          end else if (!i_last) begin
            i_q <= i_q + 1'b1;
          end else if (!j_last) begin
            j_q <= j_q + 1'b1;
            i_q <= '0;
          end else begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end

        S_EMIT: begin
          if (pair_valid && pair_ready) begin
            pair_valid <= 1'b0;
            if (pair_cnt != '1) begin
              pair_cnt <= pair_cnt + 1'b1;
            end
            // Later i for this j would only be larger matches; move on.
            if (j_last) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              j_q   <= j_q + 1'b1;
              i_q   <= '0;
              state <= S_CMP;
            end
          end
        end

        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kernel_dup_scanner.sv
// tb_kernel_dup_scanner
//
// Purpose: directed test of kernel_dup_scanner with hand-computed expected
// pairs, done cycles and pair counts. Inputs change and outputs are sampled
// on the falling clock edge. Expected values follow DUPSCAN_SKIP_ZERO_EN
// when the build defines it.
//
// Ports: none (top-level bench).

module tb_kernel_dup_scanner;

  logic       clk;
  logic       reset_n;
  logic       ld_en;
  logic [7:0] ld_data;
  logic [7:0] ke_size;
  logic       start;
  logic       busy;
  logic       done;
  logic       pair_valid;
  logic       pair_ready;
  logic [7:0] idx1;
  logic [7:0] idx2;
  logic [7:0] pair_cnt;

  int n_checks;
  int n_errors;

  // Results of the most recent run_scan call.
  int got_n;
  int got_i1 [8];
  int got_i2 [8];
  int done_cyc;
  int done_pulses;
  int busy_gaps;

  kernel_dup_scanner #(
    .WORD_WIDTH(8),
    .MAX_KE    (64)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ld_en     (ld_en),
    .ld_data   (ld_data),
    .ke_size   (ke_size),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .pair_valid(pair_valid),
    .pair_ready(pair_ready),
    .idx1      (idx1),
    .idx2      (idx2),
    .pair_cnt  (pair_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic load(input int v);
    @(negedge clk);
    ld_en   = 1'b1;
    ld_data = 8'(v);
  endtask

  task automatic load_end();
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // Starts a scan and collects every transferred pair until two cycles after
  // done (or budget cycles). Cycle 1 is the first cycle after start is sampled.
  // While stall > 0, pair_ready is held low for that many presented cycles and
  // the presented pair is compared against (stall_i1, stall_i2).
  task automatic run_scan(input int ke, input int stall, input int stall_i1,
                          input int stall_i2, input int budget);
    int stall_left;
    stall_left  = stall;
    got_n       = 0;
    done_cyc    = -1;
    done_pulses = 0;
    busy_gaps   = 0;
    @(negedge clk);
    ke_size    = 8'(ke);
    start      = 1'b1;
    pair_ready = 1'b1;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (pair_valid && stall_left > 0) begin
        pair_ready = 1'b0;
        stall_left--;
        chk("stall_idx1", int'(idx1), stall_i1);
        chk("stall_idx2", int'(idx2), stall_i2);
      end else begin
        pair_ready = 1'b1;
      end
      if (pair_valid && pair_ready) begin
        if (got_n < 8) begin
          got_i1[got_n] = int'(idx1);
          got_i2[got_n] = int'(idx2);
        end
        got_n++;
      end
      if (done_cyc < 0 && !busy) busy_gaps++;
      if (done) begin
        done_pulses++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (done_cyc >= 0 && c >= done_cyc + 2) break;
    end
    chk("busy_after_done", int'(busy), 0);
  endtask

  task automatic chk_pair(input string tag, input int k, input int e1, input int e2);
    if (k < got_n && k < 8) begin
      chk({tag, "_idx1"}, got_i1[k], e1);
      chk({tag, "_idx2"}, got_i2[k], e2);
    end else begin
      chk({tag, "_missing"}, got_n, k + 1);
    end
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    reset_n    = 1'b0;
    ld_en      = 1'b0;
    ld_data    = '0;
    ke_size    = '0;
    start      = 1'b0;
    pair_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_valid", int'(pair_valid), 0);
    chk("rst_idx1", int'(idx1), 0);
    chk("rst_idx2", int'(idx2), 0);
    chk("rst_cnt", int'(pair_cnt), 0);
    reset_n = 1'b1;

    // No duplicates: 1..9, done at 1 + 9*8/2 = 37.
    for (int k = 1; k <= 9; k++) load(k);
    load_end();
    run_scan(9, 0, 0, 0, 60);
    chk("nodup_pairs", got_n, 0);
    chk("nodup_done_cyc", done_cyc, 37);
    chk("nodup_done_pulses", done_pulses, 1);
    chk("nodup_busy_gaps", busy_gaps, 0);
    chk("nodup_cnt", int'(pair_cnt), 0);

    // Repeats [5,3,5,3,5]: pairs (0,2),(1,3),(0,4); done in cycle 9.
    load(5); load(3); load(5); load(3); load(5);
    load_end();
    run_scan(5, 0, 0, 0, 40);
    chk("rep_pairs", got_n, 3);
    chk_pair("rep_p0", 0, 0, 2);
    chk_pair("rep_p1", 1, 1, 3);
    chk_pair("rep_p2", 2, 0, 4);
    chk("rep_cnt", int'(pair_cnt), 3);
    chk("rep_done_cyc", done_cyc, 9);
    chk("rep_done_pulses", done_pulses, 1);
    chk("rep_busy_gaps", busy_gaps, 0);

    // Backpressure on the first pair for 4 cycles: everything 4 cycles later.
    load(5); load(3); load(5); load(3); load(5);
    load_end();
    run_scan(5, 4, 0, 2, 40);
    chk("bp_pairs", got_n, 3);
    chk_pair("bp_p0", 0, 0, 2);
    chk_pair("bp_p1", 1, 1, 3);
    chk_pair("bp_p2", 2, 0, 4);
    chk("bp_cnt", int'(pair_cnt), 3);
    chk("bp_done_cyc", done_cyc, 13);

    // Zero weights [0,7,0,7]: done in cycle 7 in both builds.
    load(0); load(7); load(0); load(7);
    load_end();
    run_scan(4, 0, 0, 0, 40);
`ifdef DUPSCAN_SKIP_ZERO_EN
    chk("zero_pairs", got_n, 1);
    chk_pair("zero_p0", 0, 1, 3);
    chk("zero_cnt", int'(pair_cnt), 1);
`else
    chk("zero_pairs", got_n, 2);
    chk_pair("zero_p0", 0, 0, 2);
    chk_pair("zero_p1", 1, 1, 3);
    chk("zero_cnt", int'(pair_cnt), 2);
`endif
    chk("zero_done_cyc", done_cyc, 7);

    // ke_size = 1: straight to DONE, done in cycle 1, count cleared by start.
    run_scan(1, 0, 0, 0, 10);
    chk("ke1_done_cyc", done_cyc, 1);
    chk("ke1_pairs", got_n, 0);
    chk("ke1_cnt", int'(pair_cnt), 0);
    chk("ke1_done_pulses", done_pulses, 1);

    // 64 distinct values, then a 65th write equal to entry 1 that must be
    // dropped. ke_size=200 clamps to 64: done at 1 + 64*63/2 = 2017.
    for (int k = 1; k <= 64; k++) load(k);
    load(2);
    load_end();
    run_scan(200, 0, 0, 0, 2100);
    chk("big_pairs", got_n, 0);
    chk("big_done_cyc", done_cyc, 2017);
    chk("big_done_pulses", done_pulses, 1);

    // Reset while a pair is held in EMIT.
    load(4); load(4);
    load_end();
    @(negedge clk);
    ke_size    = 8'd2;
    start      = 1'b1;
    pair_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (pair_valid) break;
    end
    chk("pre_rst_valid", int'(pair_valid), 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_valid", int'(pair_valid), 0);
    chk("mid_rst_idx1", int'(idx1), 0);
    chk("mid_rst_idx2", int'(idx2), 0);
    chk("mid_rst_cnt", int'(pair_cnt), 0);
    repeat (2) @(negedge clk);
    reset_n    = 1'b1;
    pair_ready = 1'b1;
    // Buffer is all zeros after reset.
    run_scan(2, 0, 0, 0, 20);
`ifdef DUPSCAN_SKIP_ZERO_EN
    chk("post_rst_pairs", got_n, 0);
    chk("post_rst_done_cyc", done_cyc, 2);
`else
    chk("post_rst_pairs", got_n, 1);
    chk_pair("post_rst_p0", 0, 0, 1);
    chk("post_rst_cnt", int'(pair_cnt), 1);
    chk("post_rst_done_cyc", done_cyc, 3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/kernel_dup_scanner.md
# kernel_dup_scanner

Scans a loaded kernel (lowered weight vector) for duplicated element values and emits, for each duplicated element, the index pair (first occurrence, current position). Sits directly upstream of the distance calculator: `idx1`/`idx2` feed its lowered-index inputs, one pair per valid/ready transfer. It also reports a per-kernel pair count used by the redundancy controller.

## Interface
Parameters:
- `WORD_WIDTH`, 8: weight and index width; `MAX_KE` ≤ 2^`WORD_WIDTH` required.
- `MAX_KE`, 64: weight buffer depth, i.e. the maximum kernel elements.

Ports:
- `clk` in 1: clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `ld_en` in 1: write `ld_data` at the load pointer; honoured in IDLE only.
- `ld_data` in `WORD_WIDTH`: weight value.
- `ke_size` in `WORD_WIDTH`: element count, sampled with `start`.
- `start` in 1: begin scan; honoured in IDLE only.
- `busy` out 1: high in CMP, EMIT and DONE.
- `done` out 1: one-cycle pulse at scan end.
- `pair_valid` out 1: `idx1`/`idx2` hold a pair.
- `pair_ready` in 1: consumer accepts the pair.
- `idx1` out `WORD_WIDTH`: first-occurrence index.
- `idx2` out `WORD_WIDTH`: duplicate index; always > `idx1`.
- `pair_cnt` out `WORD_WIDTH`: pairs emitted this scan; saturating.

## Operation
- Buffer: `MAX_KE` × `WORD_WIDTH` registers.
  - `wr_ptr` increments per accepted `ld_en`.
  - Writes with `wr_ptr == MAX_KE` are dropped.
  - `wr_ptr` clears in the DONE state.
- `start` latches n = min(`ke_size`, `MAX_KE`).
  - Entries not loaded since the last scan keep their old contents.
  - `pair_cnt` clears when `start` is accepted.
- FSM states: IDLE, CMP, EMIT, DONE.
- IDLE:
  - `start` with n ≥ 2 → CMP with j=1, i=0.
  - `start` with n < 2 → DONE.
  - Simultaneous `ld_en` and `start`: the write is performed; the scan uses the post-write buffer.
- CMP: one comparison per cycle, buf[i] vs buf[j].
  - Match → EMIT; registers `idx1`=i, `idx2`=j, `pair_valid`=1.
  - No match, i+1 < j → i++.
  - No match, i+1 == j, j+1 < n → j++, i=0.
  - No match, i+1 == j, j+1 == n → DONE.
  - Net effect: only the smallest matching i is reported for each j.
- EMIT: holds `idx1`/`idx2`/`pair_valid` stable until `pair_valid && pair_ready`.
  - On transfer: `pair_valid`=0, `pair_cnt`++ (saturates at all-ones).
  - Then j++, i=0 and → CMP, or → DONE if j+1 == n.
- DONE: `done`=1 for exactly this cycle, `wr_ptr`=0, → IDLE.
- `start` and `ld_en` are ignored outside IDLE.
- Reset (any state, mid-scan included):
  - State → IDLE, all buffer entries 0, `wr_ptr` 0.
  - Outputs: `busy` 0, `done` 0, `pair_valid` 0, `idx1` 0, `idx2` 0, `pair_cnt` 0.
  - An in-flight pair is lost.

## Timing
- All outputs are registered.
- `start` sampled at edge 0 → first CMP cycle is cycle 1.
- With no duplicates, `done` is high in cycle 1 + n(n−1)/2.
- Each emitted pair adds ≥ 1 EMIT cycle.
  - With `pair_ready` held high, the EMIT cycle replaces the remaining compares for that j.
- `pair_valid` rises the cycle after the matching CMP cycle.
- `pair_valid` never drops without a transfer, except on reset.
- `busy` is high from cycle 1 through the DONE cycle inclusive.

## Configuration
- `DUPSCAN_SKIP_ZERO_EN` defined:
  - A CMP where buf[j] == 0 is treated as no-match, so zero weights never produce pairs.
  - Zeros are left to the sparsity path.
- Undefined: zero weights are matched like any other value.

## Test plan
- No duplicates: load 1..9, `ke_size`=9, `start` → no `pair_valid`; `done` exactly in cycle 37; `pair_cnt`=0.
- Repeats: load [5,3,5,3,5], n=5, `pair_ready`=1 → pairs (0,2), (1,3), (0,4) in order; `pair_cnt`=3; single `done` pulse.
- Backpressure: as the repeats scenario, with `pair_ready`=0 for 4 cycles while (0,2) is presented → `idx1`/`idx2` stay 0/2 throughout; no lost or repeated pair; `pair_cnt` reaches 3.
- Zero skip: load [0,7,0,7] → pairs (1,3) only with `DUPSCAN_SKIP_ZERO_EN`; (0,2) then (1,3) without it.
- Boundaries:
  - `ke_size`=1 → `done` in cycle 1, `pair_cnt`=0.
  - `ke_size`=200 with `MAX_KE`=64 → scan limited to 64 elements.
  - A 65th `ld_en` write is dropped.
- Reset mid-scan: assert `reset_n`=0 while in EMIT → all outputs 0 immediately; after release, `start` with no new loads and `ke_size`=2 → pair (0,1), since all buffer entries were reset to 0.
